// File: rtl/pipeline_step_controller_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_step_controller_pkg
// Shared definitions for the pipeline step controller and its helpers:
// sequencer state encoding and default widths.
// -----------------------------------------------------------------------------
package pipeline_step_controller_pkg;

  localparam int unsigned BITS_REGS_DEF = 5;
  localparam int unsigned BITS_CNT_DEF  = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

endpackage

// File: rtl/pipeline_step_controller_hazard.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_detect
// Combinational load-use compare between the load in ID/EX and the source
// registers of the instruction being decoded. Register 0 never hazards.
// Ports:
//   i_idex_mem_read  load present in ID/EX
//   i_idex_rt        load destination register
//   i_ifid_rs/rt     source registers of the decoding instruction
//   o_load_use       1 when the decoding instruction must wait one cycle
// -----------------------------------------------------------------------------
module pipeline_hazard_detect
  import pipeline_step_controller_pkg::*;
#(
  parameter int unsigned BITS_REGS = BITS_REGS_DEF
) (
  input  logic                 i_idex_mem_read,
  input  logic [BITS_REGS-1:0] i_idex_rt,
  input  logic [BITS_REGS-1:0] i_ifid_rs,
  input  logic [BITS_REGS-1:0] i_ifid_rt,
  output logic                 o_load_use
);

  always_comb begin
    o_load_use = i_idex_mem_read && (i_idex_rt != '0) &&
                 ((i_idex_rt == i_ifid_rs) || (i_idex_rt == i_ifid_rt));
  end

endmodule

// File: rtl/pipeline_step_controller.sv
// -----------------------------------------------------------------------------
// pipeline_step_controller
// Central sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB latches.
// Generates per-cycle step/flush strobes (zero latency), supports continuous
// and debug single-step execution, stalls on load-use, squashes on taken
// branch and drains the pipeline on HALT.
// Ports:
//   i_clk, i_reset (async, active low)
//   i_start, i_mode_continuous, i_step_req, i_clear   run control
//   i_idex_mem_read, i_idex_rt, i_ifid_rs, i_ifid_rt   load-use inputs
//   i_branch_taken, i_halt_id, i_halt_wb                flow control
//   o_pc_en, o_*_step, o_*_flush                        latch strobes
//   o_running, o_halted                                 status
//   o_cycle_count, o_stall_count                        saturating counters
// -----------------------------------------------------------------------------
module pipeline_step_controller
  import pipeline_step_controller_pkg::*;
#(
  parameter int unsigned BITS_REGS = BITS_REGS_DEF,
  parameter int unsigned BITS_CNT  = BITS_CNT_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_mode_continuous,
  input  logic                 i_step_req,
  input  logic                 i_clear,
  input  logic                 i_idex_mem_read,
  input  logic [BITS_REGS-1:0] i_idex_rt,
  input  logic [BITS_REGS-1:0] i_ifid_rs,
  input  logic [BITS_REGS-1:0] i_ifid_rt,
  input  logic                 i_branch_taken,
  input  logic                 i_halt_id,
  input  logic                 i_halt_wb,
  output logic                 o_pc_en,
  output logic                 o_ifid_step,
  output logic                 o_ifid_flush,
  output logic                 o_idex_step,
  output logic                 o_idex_flush,
  output logic                 o_exmem_step,
  output logic                 o_memwb_step,
  output logic                 o_running,
  output logic                 o_halted,
  output logic [BITS_CNT-1:0]  o_cycle_count,
  output logic [BITS_CNT-1:0]  o_stall_count
);

  state_t              r_state, w_state_nxt;
  logic                r_mode;
  logic                r_step_prev;
  logic [BITS_CNT-1:0] r_cycle_cnt, r_stall_cnt;

  logic w_load_use, w_step_pulse, w_active, w_adv, w_in_run, w_stall_inc;

  pipeline_hazard_detect #(
    .BITS_REGS(BITS_REGS)
  ) u_hazard (
    .i_idex_mem_read(i_idex_mem_read),
    .i_idex_rt      (i_idex_rt),
    .i_ifid_rs      (i_ifid_rs),
    .i_ifid_rt      (i_ifid_rt),
    .o_load_use     (w_load_use)
  );

  always_comb begin
    w_step_pulse = i_step_req && !r_step_prev;
    w_in_run     = (r_state == RUN);
    w_active     = (r_state == RUN) || (r_state == DRAIN);
    w_adv        = w_active && (r_mode || w_step_pulse);
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_stall_inc  = 1'b0;
    o_pc_en      = 1'b0;
    o_ifid_step  = 1'b0;
    o_ifid_flush = 1'b0;
    o_idex_step  = 1'b0;
    o_idex_flush = 1'b0;
    o_exmem_step = 1'b0;
    o_memwb_step = 1'b0;
    case (r_state)
      IDLE: if (i_start) w_state_nxt = RUN;
      RUN, DRAIN: begin
        if (w_adv) begin
          // DRAIN reuses the RUN priority chain with PC frozen and IF/ID
          // always flushed, since anything fetched after HALT is discarded.
          o_exmem_step = 1'b1;
          o_memwb_step = 1'b1;
          if (i_branch_taken) begin
            o_pc_en      = w_in_run;
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
          end else if (w_load_use) begin
            o_ifid_flush = !w_in_run;
            o_idex_flush = 1'b1;
            w_stall_inc  = 1'b1;
          end else begin
            o_pc_en      = w_in_run;
            o_ifid_step  = w_in_run;
            o_ifid_flush = !w_in_run;
            o_idex_step  = 1'b1;
          end
          if (i_halt_wb) begin
            w_state_nxt = HALTED;
          end else if (w_in_run && i_halt_id && !i_branch_taken) begin
            w_state_nxt = DRAIN;
          end
        end
      end
      HALTED: if (i_clear) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= IDLE;
      r_mode      <= 1'b0;
      r_step_prev <= 1'b0;
      r_cycle_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_step_prev <= i_step_req;
      if (r_state == IDLE && i_start) begin
        r_mode      <= i_mode_continuous;
        r_cycle_cnt <= '0;
        r_stall_cnt <= '0;
      end else if (r_state == HALTED && i_clear) begin
        r_cycle_cnt <= '0;
        r_stall_cnt <= '0;
      end else if (w_adv) begin
        if (r_cycle_cnt != '1) r_cycle_cnt <= r_cycle_cnt + 1'b1;
        if (w_stall_inc && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    o_running     = w_active;
    o_halted      = (r_state == HALTED);
    o_cycle_count = r_cycle_cnt;
    o_stall_count = r_stall_cnt;
  end

endmodule

// File: tb/tb_pipeline_step_controller.sv
// -----------------------------------------------------------------------------
// tb_pipeline_step_controller
// Scoreboarded bench: each driven cycle pushes the expected strobes/status,
// which are popped and compared mid-cycle against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_pipeline_step_controller;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_start = 1'b0, i_mode_continuous = 1'b0, i_step_req = 1'b0, i_clear = 1'b0;
  logic        i_idex_mem_read = 1'b0;
  logic [4:0]  i_idex_rt = '0, i_ifid_rs = '0, i_ifid_rt = '0;
  logic        i_branch_taken = 1'b0, i_halt_id = 1'b0, i_halt_wb = 1'b0;
  logic        o_pc_en, o_ifid_step, o_ifid_flush, o_idex_step, o_idex_flush;
  logic        o_exmem_step, o_memwb_step, o_running, o_halted;
  logic [31:0] o_cycle_count, o_stall_count;

  always #5 i_clk = ~i_clk;

  pipeline_step_controller #(
    .BITS_REGS(5),
    .BITS_CNT (32)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
    .i_mode_continuous(i_mode_continuous), .i_step_req(i_step_req), .i_clear(i_clear),
    .i_idex_mem_read(i_idex_mem_read), .i_idex_rt(i_idex_rt),
    .i_ifid_rs(i_ifid_rs), .i_ifid_rt(i_ifid_rt),
    .i_branch_taken(i_branch_taken), .i_halt_id(i_halt_id), .i_halt_wb(i_halt_wb),
    .o_pc_en(o_pc_en), .o_ifid_step(o_ifid_step), .o_ifid_flush(o_ifid_flush),
    .o_idex_step(o_idex_step), .o_idex_flush(o_idex_flush),
    .o_exmem_step(o_exmem_step), .o_memwb_step(o_memwb_step),
    .o_running(o_running), .o_halted(o_halted),
    .o_cycle_count(o_cycle_count), .o_stall_count(o_stall_count)
  );

  typedef struct {
    logic [6:0]  st;   // {pc_en, ifid_step, ifid_flush, idex_step, idex_flush, exmem, memwb}
    logic        run;
    logic        hlt;
    logic [31:0] cyc;
    logic [31:0] stl;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  // reference model state
  int          m_st = 0;   // 0 idle, 1 run, 2 drain, 3 halted
  bit          m_mode = 0, m_prev = 0;
  logic [31:0] m_cyc = '0, m_stl = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] strobes();
    return {o_pc_en, o_ifid_step, o_ifid_flush, o_idex_step, o_idex_flush,
            o_exmem_step, o_memwb_step};
  endfunction

  always @(negedge i_clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("steps",     32'(strobes()),   32'(mon_e.st));
      chk("running",   32'(o_running),   32'(mon_e.run));
      chk("halted",    32'(o_halted),    32'(mon_e.hlt));
      chk("cycle_cnt", o_cycle_count,    mon_e.cyc);
      chk("stall_cnt", o_stall_count,    mon_e.stl);
    end
  end

  // Called at posedge+1: drive one cycle, push expectation, advance model.
  task automatic drv(input logic start, input logic mc, input logic req, input logic clr,
                     input logic mr, input logic [4:0] irt, input logic [4:0] rs,
                     input logic [4:0] rt, input logic br, input logic hid, input logic hwb);
    exp_t       e;
    bit         adv, lu;
    logic [6:0] s;
    i_start = start; i_mode_continuous = mc; i_step_req = req; i_clear = clr;
    i_idex_mem_read = mr; i_idex_rt = irt; i_ifid_rs = rs; i_ifid_rt = rt;
    i_branch_taken = br; i_halt_id = hid; i_halt_wb = hwb;
    adv = (m_st == 1 || m_st == 2) && (m_mode || (req && !m_prev));
    lu  = mr && (irt != 5'd0) && (irt == rs || irt == rt);
    s   = 7'b0;
    if (adv) begin
      if (m_st == 1) s = br ? 7'b1010111 : (lu ? 7'b0000111 : 7'b1101011);
      else           s = br ? 7'b0010111 : (lu ? 7'b0010111 : 7'b0011011);
    end
    e.st = s; e.run = (m_st == 1 || m_st == 2); e.hlt = (m_st == 3);
    e.cyc = m_cyc; e.stl = m_stl;
    q.push_back(e);
    @(posedge i_clk);
    #1;
    if (m_st == 0 && start) begin
      m_mode = mc; m_cyc = '0; m_stl = '0; m_st = 1;
    end else if (m_st == 3 && clr) begin
      m_cyc = '0; m_stl = '0; m_st = 0;
    end else if (adv) begin
      if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
      if (lu && !br && m_stl != 32'hFFFF_FFFF) m_stl = m_stl + 1;
      if (hwb) m_st = 3;
      else if (m_st == 1 && hid && !br) m_st = 2;
    end
    m_prev = req;
  endtask

  task automatic run(input int n, input logic req);
    for (int i = 0; i < n; i++) drv(1'b0, 1'b0, req, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    m_st = 0; m_mode = 0; m_prev = 0; m_cyc = '0; m_stl = '0;
  endtask

  initial begin
    // power-on reset
    #2;
    chk("rst_steps",   32'(strobes()), 32'd0);
    chk("rst_running", 32'(o_running), 32'd0);
    chk("rst_halted",  32'(o_halted),  32'd0);
    chk("rst_cycle",   o_cycle_count,  32'd0);
    chk("rst_stall",   o_stall_count,  32'd0);
    #10 i_reset = 1'b1;
    @(posedge i_clk); #1;

    // continuous run, then reset mid-RUN with the counters at 7
    drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    run(7, 1'b0);
    #1;
    chk("pre_rst_cycle", o_cycle_count, 32'd7);
    chk("pre_rst_steps", 32'(strobes()), 32'h6B);
    i_reset = 1'b0;
    #1;
    chk("mid_rst_steps",   32'(strobes()), 32'd0);
    chk("mid_rst_running", 32'(o_running), 32'd0);
    model_reset();
    @(posedge i_clk); #3 i_reset = 1'b1;
    @(posedge i_clk); #1;
    chk("post_rst_cycle",   o_cycle_count, 32'd0);
    chk("post_rst_stall",   o_stall_count, 32'd0);
    chk("post_rst_running", 32'(o_running), 32'd0);

    // 10 free-running cycles
    drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    run(10, 1'b0);

    // load-use on rs, rt==0 (no stall), load-use on rt, branch beats load-use
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
    // start/clear ignored in RUN; halt_id with taken branch does not drain
    drv(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);

    // HALT drain
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    run(2, 1'b0);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    run(2, 1'b0);
    drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    drv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    run(1, 1'b0);

    // debug single-step: 3 level pulses of 5 cycles -> 3 advances
    drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      run(5, 1'b1);
      run(5, 1'b0);
    end
    run(2, 1'b0);
    // halt_wb seen in RUN on a step edge goes straight to HALTED
    drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    run(2, 1'b0);
    drv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    run(1, 1'b0);

    if (q.size() != 0) begin
      chk("queue_drained", 32'(q.size()), 32'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_step_controller.md
Name: pipeline_step_controller

Overview:
- Central sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline latches. Generates every latch's per-cycle step (advance) and flush strobes.
- Supports continuous and debug single-step execution, detects load-use hazards, squashes on taken branch/jump, and drains the pipeline on HALT.
- Sits beside the datapath. Its step/flush outputs drive the latches' step and flush_latch inputs directly.

Parameters:
- BITS_REGS, 5, register-index width.
- BITS_CNT, 32, width of the cycle and stall counters.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_start  in  1  pulse; leaves IDLE and begins execution.
- i_mode_continuous  in  1  1 = free-run, 0 = debug single-step; sampled only on i_start.
- i_step_req  in  1  debug step request (level); each rising edge gives one advance.
- i_clear  in  1  pulse; returns HALTED to IDLE and zeroes the counters.
- i_idex_mem_read  in  1  load currently in the ID/EX latch.
- i_idex_rt  in  BITS_REGS  destination rt held in the ID/EX latch.
- i_ifid_rs  in  BITS_REGS  rs of the instruction being decoded.
- i_ifid_rt  in  BITS_REGS  rt of the instruction being decoded.
- i_branch_taken  in  1  branch/jump resolved taken in EX this cycle.
- i_halt_id  in  1  HALT decoded in ID.
- i_halt_wb  in  1  HALT reached WB.
- o_pc_en  out  1  PC update enable.
- o_ifid_step  out  1  IF/ID latch step.
- o_ifid_flush  out  1  IF/ID latch flush.
- o_idex_step  out  1  ID/EX latch step.
- o_idex_flush  out  1  ID/EX latch flush (bubble).
- o_exmem_step  out  1  EX/MEM latch step.
- o_memwb_step  out  1  MEM/WB latch step.
- o_running  out  1  state is RUN or DRAIN.
- o_halted  out  1  state is HALTED.
- o_cycle_count  out  BITS_CNT  number of advance cycles since start.
- o_stall_count  out  BITS_CNT  number of load-use stall cycles since start.

Behaviour:
- States: IDLE, RUN, DRAIN, HALTED.
- Reset (async, i_reset=0): state=IDLE, mode_q=0, step edge register=0, both counters=0. All outputs are 0 while in reset.
- mode_q: latched from i_mode_continuous on i_start in IDLE. Held constant until the block returns to IDLE.
- step_pulse: i_step_req & ~step_prev, where step_prev is a registered copy of i_step_req. Multiple edges while an advance is pending are not queued.
- adv = (state==RUN | state==DRAIN) & (mode_q | step_pulse).
- Transitions:
  - IDLE -> RUN on i_start. The counters are zeroed in the same cycle.
  - RUN -> DRAIN on adv & i_halt_id & ~i_branch_taken.
  - DRAIN -> HALTED on adv & i_halt_wb. The halt_wb check also applies in RUN as a safety path: RUN -> HALTED.
  - HALTED -> IDLE on i_clear. The counters are zeroed.
  - i_start is ignored outside IDLE. i_clear is ignored outside HALTED.
- Outputs are combinational from state, adv and hazard inputs (zero-latency), so the latches update on the same edge.
- load_use = i_idex_mem_read & (i_idex_rt != 0) & (i_idex_rt == i_ifid_rs | i_idex_rt == i_ifid_rt).
- When adv=0: every step and flush output is 0 and the pipeline is frozen.
- RUN, adv=1, priority order:
  1. i_branch_taken: o_pc_en=1, o_ifid_flush=1, o_idex_flush=1, exmem/memwb step=1. Load-use is ignored.
  2. load_use: o_pc_en=0, o_ifid_step=0, o_idex_flush=1, exmem/memwb step=1. o_stall_count increments.
  3. Otherwise: o_pc_en, o_ifid_step, o_idex_step, o_exmem_step and o_memwb_step are all 1.
- DRAIN, adv=1: o_pc_en=0, o_ifid_flush=1, idex/exmem/memwb step=1. Load-use and branch squash still apply as in RUN, but o_pc_en stays 0.
- Flush outputs are asserted only with adv. Flush has priority inside the latch, so a step output is don't-care whenever its flush is 1; the controller drives it 0.
- o_cycle_count increments on every adv. Both counters saturate at all-ones (no wrap).
- Reset mid-operation returns to IDLE immediately. No latch is stepped until the next i_start.

Decomposition:
- Shared package/include holds the state encoding localparams (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, HALTED=2'd3) and the BITS_REGS default.
- One natural sub-module: pipeline_hazard_detect, a combinational load_use compare. It is reused later for forwarding checks.

Test Plan:
- Reset low mid-RUN with the counters at 7 -> all outputs 0 immediately; state IDLE; counters 0 after reset release.
- i_start with mode=1, no hazards, 10 cycles -> all step outputs 1 every cycle; o_cycle_count=10; o_stall_count=0.
- i_idex_mem_read=1, i_idex_rt=5, i_ifid_rs=5 for one cycle -> o_pc_en=0, o_ifid_step=0, o_idex_flush=1, o_exmem_step=1, o_stall_count=1. Repeat with i_idex_rt=0 -> no stall.
- i_branch_taken=1 together with a load_use match -> o_ifid_flush=1, o_idex_flush=1, o_pc_en=1; o_stall_count unchanged.
- Mode=0, i_step_req held high 5 cycles then low, repeated 3 times -> exactly 3 advance cycles; o_cycle_count=3.
- i_halt_id in RUN -> DRAIN with o_pc_en=0 and o_ifid_flush=1; after i_halt_wb -> o_halted=1 and all steps 0; i_clear -> IDLE with counters 0.
